// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master: size encodings,
// FSM states, the latched request context and lane/alignment functions.
package lsu_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_X = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic       write;
      size_e      size;
      logic       sext;
      logic [1:0] off;
   } req_ctx_t;

   function automatic logic [MASK_W-1:0] lane_mask(input size_e size, input logic [1:0] off);
      logic [MASK_W-1:0] m;
      case (size)
         SZ_B:    m = MASK_W'(4'b0001 << off);
         SZ_H:    m = MASK_W'(4'b0011 << off);
         SZ_W:    m = 4'b1111;
         default: m = '0;
      endcase
      return m;
   endfunction

   // Illegal size is folded in so a single test decides whether memory is touched.
   function automatic logic misaligned(input size_e size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = off[0];
         SZ_W:    bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Bundles the execute-side request/response handshake and the data-memory bus.
interface lsu_mem_master_if;
   import lsu_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   logic              mem_valid;
   logic              mem_ready;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [MASK_W-1:0] mem_wmask;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      input  resp_ready,
      output mem_valid, mem_write, mem_addr, mem_wdata, mem_wmask,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      output resp_ready,
      input  mem_valid, mem_write, mem_addr, mem_wdata, mem_wmask,
      output mem_ready, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store mask/data replication from the incoming
// request, and load extraction/extension from the latched request context.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  size_e             st_size,
   input  logic [1:0]        st_off,
   input  logic [DATA_W-1:0] st_data,
   input  size_e             ld_size,
   input  logic [1:0]        ld_off,
   input  logic              ld_sext,
   input  logic [DATA_W-1:0] ld_rdata,
   output logic [MASK_W-1:0] mask_c,
   output logic [DATA_W-1:0] wdata_c,
   output logic [DATA_W-1:0] rdata_c
);

   logic [DATA_W-1:0] sh;

   // Replicating the narrow datum puts it on the right lane for any offset.
   always_comb begin
      mask_c = lane_mask(st_size, st_off);
      case (st_size)
         SZ_B:    wdata_c = {4{st_data[7:0]}};
         SZ_H:    wdata_c = {2{st_data[15:0]}};
         default: wdata_c = st_data;
      endcase
   end

   always_comb begin
      sh = ld_rdata >> {ld_off, 3'b000};
      case (ld_size)
         SZ_B:    rdata_c = {{24{ld_sext & sh[7]}}, sh[7:0]};
         SZ_H:    rdata_c = {{16{ld_sext & sh[15]}}, sh[15:0]};
         default: rdata_c = sh;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Data-memory initiator: one load/store in flight, alignment checks, lane
// steering, bounded wait for read data and a held response to the execute stage.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              clock,
   input  logic              reset,
   lsu_mem_master_if.master  bus
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e            state;
   req_ctx_t          ctx;
   logic [TMR_W-1:0]  timer;

   size_e             in_size_c;
   logic [1:0]        in_off_c;
   logic [MASK_W-1:0] mask_c;
   logic [DATA_W-1:0] wdata_c;
   logic [DATA_W-1:0] rdata_c;

   assign in_size_c = size_e'(bus.req_size);
   assign in_off_c  = bus.req_addr[1:0];

   lsu_lane_align u_align (
      .st_size  (in_size_c),
      .st_off   (in_off_c),
      .st_data  (bus.req_wdata),
      .ld_size  (ctx.size),
      .ld_off   (ctx.off),
      .ld_sext  (ctx.sext),
      .ld_rdata (bus.mem_rdata),
      .mask_c   (mask_c),
      .wdata_c  (wdata_c),
      .rdata_c  (rdata_c)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= ST_IDLE;
         ctx            <= '0;
         timer          <= '0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_rdata <= '0;
         bus.mem_valid  <= 1'b0;
         bus.mem_write  <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.mem_wmask  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  ctx.write     <= bus.req_write;
                  ctx.size      <= in_size_c;
                  ctx.sext      <= bus.req_signed;
                  ctx.off       <= in_off_c;
                  bus.req_ready <= 1'b0;
                  if (misaligned(in_size_c, in_off_c)) begin
                     state          <= ST_RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                     bus.resp_rdata <= '0;
                  end else begin
                     state         <= ST_ISSUE;
                     timer         <= '0;
                     bus.mem_valid <= 1'b1;
                     bus.mem_write <= bus.req_write;
                     bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                     bus.mem_wdata <= wdata_c;
                     bus.mem_wmask <= mask_c;
                  end
               end
            end

            // Request is held untouched until the memory accepts it.
            ST_ISSUE: begin
               if (bus.mem_ready) begin
                  bus.mem_valid <= 1'b0;
                  if (ctx.write) begin
                     state          <= ST_RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b0;
                     bus.resp_rdata <= '0;
                  end else if (bus.mem_rvalid) begin
                     state          <= ST_RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b0;
                     bus.resp_rdata <= rdata_c;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end

            ST_WAIT: begin
               timer <= timer + TMR_W'(1);
               if (bus.mem_rvalid) begin
                  state          <= ST_RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b0;
                  bus.resp_rdata <= rdata_c;
               end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  state          <= ST_RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b1;
                  bus.resp_rdata <= '0;
               end
            end

            // req_ready rises only after the handshake, so no same-cycle re-accept.
            ST_RESP: begin
               if (bus.resp_ready) begin
                  state          <= ST_IDLE;
                  bus.resp_valid <= 1'b0;
                  bus.resp_err   <= 1'b0;
                  bus.resp_rdata <= '0;
                  bus.req_ready  <= 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
